// File: rtl/fft32_sdf_ctrl_if.sv
// Control bus between the SDF FFT sequencer and its neighbours.
//  master : the sequencer (drives everything except in_valid)
//  slave  : the sample source / stage datapath side
// Signals:
//  in_valid   source has a sample this cycle
//  in_ready   sequencer accepts the sample
//  adv        pipeline advance enable for every stage
//  bf_mode    per-stage butterfly phase flags
//  tw_idx     packed per-stage twiddle ROM indices
//  out_valid  pipeline output holds a real result
//  out_idx    bit-reversed-order position of the output in its frame
//  out_first  first output of a frame
//  frame_done last output of a frame
//  busy       sequencer not idle
//  state      0 IDLE, 1 RUN, 2 FLUSH
interface fft32_sdf_ctrl_if #(
  parameter int unsigned LOG2N = 5
);
  logic                             in_valid;
  logic                             in_ready;
  logic                             adv;
  logic [LOG2N-1:0]                 bf_mode;
  logic [(LOG2N-1)*(LOG2N-1)-1:0]   tw_idx;
  logic                             out_valid;
  logic [LOG2N-1:0]                 out_idx;
  logic                             out_first;
  logic                             frame_done;
  logic                             busy;
  logic [1:0]                       state;

  modport master (
    input  in_valid,
    output in_ready, adv, bf_mode, tw_idx, out_valid, out_idx,
           out_first, frame_done, busy, state
  );

  modport slave (
    output in_valid,
    input  in_ready, adv, bf_mode, tw_idx, out_valid, out_idx,
           out_first, frame_done, busy, state
  );
endinterface

// File: rtl/fft32_sdf_ctrl.sv
// Sequencer for a radix-2 DIF single-path-delay-feedback FFT pipeline.
// Counts accepted samples, derives each stage's butterfly phase and twiddle
// index, tracks pipeline fill, stalls and end-of-stream flush, and marks
// valid outputs and frame boundaries.
// Ports:
//  clk  rising-edge clock
//  rst  synchronous active-high reset
//  bus  control bus (master side), see fft32_sdf_ctrl_if
module fft32_sdf_ctrl #(
  parameter int unsigned LOG2N     = 5,
  parameter int unsigned STAGE_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  fft32_sdf_ctrl_if.master bus
);
  localparam int unsigned N   = 1 << LOG2N;
  localparam int unsigned LAT = N - 1 + LOG2N * STAGE_LAT;
  localparam int unsigned PW  = $clog2(LAT + N + 1);
  localparam int unsigned WW  = $clog2(LAT + 1);
  localparam int unsigned TW  = LOG2N - 1;

  localparam logic [WW-1:0]    LAT_W = WW'(LAT);
  localparam logic [LOG2N-1:0] LAT_C = LOG2N'(LAT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]       r_state;
  logic [LOG2N-1:0] r_c;
  logic [PW-1:0]    r_pend;
  logic [WW-1:0]    r_warm;

  logic             w_flush_now;
  logic [1:0]       w_state;
  logic [1:0]       w_state_nxt;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_adv;
  logic             w_out_valid;
  logic [LOG2N-1:0] w_out_idx;
  logic [PW-1:0]    w_pend_nxt;
  logic [LOG2N-1:0] w_bf_mode;
  logic [TW*TW-1:0] w_tw_idx;

  always_comb begin
    // RUN -> FLUSH takes effect in the same cycle the stream ends, so the
    // first dummy advance is not lost; the visible state reflects it.
    w_flush_now = (r_state == S_RUN) && !bus.in_valid &&
                  (r_c == '0) && (r_pend != '0);
    w_state     = w_flush_now ? S_FLUSH : r_state;
    w_in_ready  = !((w_state == S_FLUSH) && (r_c != '0));
    w_accept    = bus.in_valid && w_in_ready;
    w_adv       = (w_state == S_FLUSH) || w_accept;
    w_out_valid = w_adv && (r_warm == LAT_W) && (r_pend != '0);
    w_out_idx   = r_c - LAT_C;
    w_pend_nxt  = r_pend + PW'(w_accept) - PW'(w_out_valid);

    w_state_nxt = w_state;
    case (w_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      S_FLUSH: begin
        if (w_accept)                w_state_nxt = S_RUN;
        else if (w_pend_nxt == '0)   w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-stage phase: stage s sees the sample counter delayed by D_s.
  always_comb begin : b_stage
    logic [LOG2N-1:0] cs;
    logic [31:0]      d;
    logic [31:0]      tw;
    w_bf_mode = '0;
    w_tw_idx  = '0;
    cs        = '0;
    d         = '0;
    tw        = '0;
    for (int unsigned s = 0; s < LOG2N; s++) begin
      d            = N - (32'd1 << (LOG2N - s)) + s * STAGE_LAT;
      cs           = r_c - d[LOG2N-1:0];
      w_bf_mode[s] = cs[LOG2N-1-s];
      if (s < LOG2N - 1) begin
        tw = (32'(cs) & ((32'd1 << (LOG2N - 1 - s)) - 32'd1)) << s;
        w_tw_idx[s*TW +: TW] = cs[LOG2N-1-s] ? '0 : tw[TW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_pend  <= '0;
      r_warm  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      if (w_state_nxt == S_IDLE) begin
        r_c    <= '0;
        r_warm <= '0;
      end else if (w_adv) begin
        r_c    <= r_c + LOG2N'(1);
        r_warm <= (r_warm == LAT_W) ? r_warm : r_warm + WW'(1);
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.adv        = w_adv;
  assign bus.bf_mode    = w_bf_mode;
  assign bus.tw_idx     = w_tw_idx;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_idx    = w_out_idx;
  assign bus.out_first  = w_out_valid && (w_out_idx == '0);
  assign bus.frame_done = w_out_valid && (w_out_idx == '1);
  assign bus.busy       = (w_state != S_IDLE);
  assign bus.state      = w_state;
endmodule
